// File: rtl/axi_llc_way_arbiter_pkg.sv
// Shared LLC types for the data-way arbiter: unit encodings, way payloads,
// macro latency and the outstanding-read bound derived from it.
package axi_llc_way_arbiter_pkg;

    typedef enum logic [1:0] {
        R_UNIT      = 2'd0,
        W_UNIT      = 2'd1,
        EVICT_UNIT  = 2'd2,
        REFILL_UNIT = 2'd3
    } cache_unit_e;

    localparam int unsigned DataMacroLatency = 1;
    localparam int unsigned NumUnits         = 4;
    localparam int unsigned MaxReads         = DataMacroLatency + 2;
    localparam int unsigned UnitIdxW         = $clog2(NumUnits);
    localparam int unsigned FifoCntW         = $clog2(MaxReads + 1);
    localparam int unsigned WayAddrW         = 8;
    localparam int unsigned WayDataW         = 16;

    typedef logic [UnitIdxW-1:0] unit_idx_t;

    typedef struct packed {
        cache_unit_e           cache_unit;
        logic                  we;
        logic [WayAddrW-1:0]   addr;
        logic [WayDataW-1:0]   wdata;
    } way_inp_t;

    typedef struct packed {
        cache_unit_e           cache_unit;
        logic [WayDataW-1:0]   data;
    } way_oup_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic unit_idx_t next_unit(unit_idx_t idx);
        return (idx == unit_idx_t'(NumUnits - 1)) ? '0 : idx + unit_idx_t'(1);
    endfunction

endpackage

// File: rtl/axi_llc_way_arbiter_if.sv
// Unit-side and way-side request/response bundle of the way arbiter.
// valid/ready: a transfer happens on a cycle where both are high; a raised valid with its payload is held until that cycle.
interface axi_llc_way_arbiter_if;
    import axi_llc_way_arbiter_pkg::*;

    way_inp_t   [NumUnits-1:0] unit_inp_i;
    logic       [NumUnits-1:0] unit_inp_valid_i;
    logic       [NumUnits-1:0] unit_inp_ready_o;
    way_oup_t   [NumUnits-1:0] unit_out_o;
    logic       [NumUnits-1:0] unit_out_valid_o;
    logic       [NumUnits-1:0] unit_out_ready_i;
    way_inp_t                  way_inp_o;
    logic                      way_inp_valid_o;
    logic                      way_inp_ready_i;
    way_oup_t                  way_out_i;
    logic                      way_out_valid_i;
    logic                      way_out_ready_o;

    arb_state_e                dbg_state_o;
    unit_idx_t                 dbg_prio_o;
    unit_idx_t                 dbg_sel_o;
    logic [FifoCntW-1:0]       dbg_fifo_usage_o;
    logic                      dbg_fifo_full_o;
    logic                      dbg_fifo_empty_o;

    modport slave (
        input  unit_inp_i, unit_inp_valid_i, unit_out_ready_i,
               way_inp_ready_i, way_out_i, way_out_valid_i,
        output unit_inp_ready_o, unit_out_o, unit_out_valid_o,
               way_inp_o, way_inp_valid_o, way_out_ready_o,
               dbg_state_o, dbg_prio_o, dbg_sel_o,
               dbg_fifo_usage_o, dbg_fifo_full_o, dbg_fifo_empty_o
    );

    modport master (
        output unit_inp_i, unit_inp_valid_i, unit_out_ready_i,
               way_inp_ready_i, way_out_i, way_out_valid_i,
        input  unit_inp_ready_o, unit_out_o, unit_out_valid_o,
               way_inp_o, way_inp_valid_o, way_out_ready_o,
               dbg_state_o, dbg_prio_o, dbg_sel_o,
               dbg_fifo_usage_o, dbg_fifo_full_o, dbg_fifo_empty_o
    );

endinterface

// File: rtl/axi_llc_way_arbiter_fifo.sv
// Non-fall-through FIFO (fifo_v3 style) holding the unit index of each
// outstanding read; head is the registered storage entry.
module axi_llc_way_arbiter_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             testmode_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  usage_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             push_i,
    output logic [WIDTH-1:0] data_o,
    input  logic             pop_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok, mem_en;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage enable stands in for the clock gate; testmode keeps it open.
    assign mem_en = push_i | flush_i | testmode_i;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        push_ok  = push_i & (~full_o | pop_i);
        pop_ok   = pop_i & ~empty_o;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (mem_en) begin
                mem_q <= mem_d;
            end
        end
    end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// Round-robin arbiter sharing the LLC data-way port between units; records
// each read's issuer and routes the in-order read data back to it.
module axi_llc_way_arbiter
    import axi_llc_way_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_i,
    axi_llc_way_arbiter_if.slave   bus
);

    arb_state_e          state_q, state_d;
    unit_idx_t           prio_q, prio_d, sel_q, sel_d;
    unit_idx_t           sel, winner, idx, fifo_head;
    logic [NumUnits-1:0] eligible;
    logic                found, req_valid, req_hs;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FifoCntW-1:0] fifo_usage;

    always_comb begin
        for (int i = 0; i < NumUnits; i++) begin
            eligible[i] = bus.unit_inp_valid_i[i] & (bus.unit_inp_i[i].we | ~fifo_full);
        end
        found  = 1'b0;
        winner = prio_q;
        idx    = prio_q;
        for (int k = 0; k < NumUnits; k++) begin
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = next_unit(idx);
        end

        // A stalled grant stays on its unit even if the FIFO fills meanwhile.
        sel       = (state_q == ARB_LOCKED) ? sel_q : winner;
        req_valid = (state_q == ARB_LOCKED) ? bus.unit_inp_valid_i[sel_q] : found;
        req_hs    = req_valid & bus.way_inp_ready_i;

        bus.way_inp_o       = bus.unit_inp_i[sel];
        bus.way_inp_valid_o = req_valid;
        // Gated by valid so a blocked read at the idle pointer is never acked.
        bus.unit_inp_ready_o      = '0;
        bus.unit_inp_ready_o[sel] = bus.way_inp_ready_i & req_valid;

        fifo_push = req_hs & ~bus.unit_inp_i[sel].we;

        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        if (req_hs) begin
            state_d = ARB_IDLE;
            prio_d  = next_unit(sel);
        end else if (req_valid) begin
            state_d = ARB_LOCKED;
            sel_d   = sel;
        end else begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            prio_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        bus.unit_out_valid_o = '0;
        if (!fifo_empty) begin
            bus.unit_out_valid_o[fifo_head] = bus.way_out_valid_i;
        end
        bus.way_out_ready_o = ~fifo_empty & bus.unit_out_ready_i[fifo_head];
        fifo_pop            = bus.way_out_valid_i & bus.way_out_ready_o;
    end

    assign bus.unit_out_o = {NumUnits{bus.way_out_i}};

    axi_llc_way_arbiter_fifo #(
        .DEPTH (MaxReads),
        .WIDTH (UnitIdxW)
    ) u_route_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (1'b0),
        .testmode_i (test_i),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (sel),
        .push_i     (fifo_push),
        .data_o     (fifo_head),
        .pop_i      (fifo_pop)
    );

    assign bus.dbg_state_o      = state_q;
    assign bus.dbg_prio_o       = prio_q;
    assign bus.dbg_sel_o        = sel_q;
    assign bus.dbg_fifo_usage_o = fifo_usage;
    assign bus.dbg_fifo_full_o  = fifo_full;
    assign bus.dbg_fifo_empty_o = fifo_empty;

    stray_read_data_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.way_out_valid_i && fifo_empty));

endmodule
